adc_sample_reader: RTL

Serial capture engine for the receive-path ADC. It frames conversions with `adc_cs` against the free-running `adc_clk`, which is `clk48` passed through at top level, and shifts in `adc_sdo`. It strips and checks the leading-zero bits and converts offset-binary codes to two's complement. Samples go out on a valid/ready handshake to the correlator input path. It is the receive-side counterpart of the DAC serializer that drives `dac_cs` and `dac_sdi`.

---
 rtl/capstone_pkg.sv | 22 ++
 rtl/adc_sample_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/capstone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : capstone_pkg
//  Description : Shared constants and state encoding for the ADC capture
//                path (converter resolution, leading-zero count, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package capstone_pkg;

    // Converter resolution and number of leading-zero bits before the MSB
    localparam int ADC_DATA_BITS = 12;
    localparam int ADC_LEAD_BITS = 4;

    // Capture engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } adc_state_t;

endpackage : capstone_pkg
`default_nettype wire

// File: rtl/adc_sample_reader.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_reader
//  Description : Serial ADC capture engine. Frames conversions with adc_cs,
//                shifts in adc_sdo MSB first, checks the leading-zero bits,
//                converts offset binary to two's complement and presents the
//                sample on a valid/ready handshake with overrun tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_reader
    import capstone_pkg::*;
#(
    parameter int DATA_BITS    = ADC_DATA_BITS,
    parameter int LEAD_BITS    = ADC_LEAD_BITS,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                 clk48,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 adc_sdo,
    output logic                 adc_cs,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic [7:0]           overrun_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_FRAME  = LEAD_BITS + DATA_BITS;
    localparam int c_CNT_W  = $clog2(c_FRAME);
    localparam int c_QCNT_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0]  c_LAST_BIT   = c_CNT_W'(c_FRAME - 1);
    localparam logic [c_QCNT_W-1:0] c_LAST_QUIET = c_QCNT_W'(QUIET_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    adc_state_t            r_state;
    adc_state_t            w_state_nxt;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [c_CNT_W-1:0]    w_bit_cnt_nxt;
    logic [c_QCNT_W-1:0]   r_quiet_cnt;
    logic [c_QCNT_W-1:0]   w_quiet_cnt_nxt;
    // Holds the first FRAME-1 bits; the last bit is taken straight from the pin
    logic [c_FRAME-2:0]    r_shift;
    logic [c_FRAME-2:0]    w_shift_nxt;
    logic                  r_cs;
    logic                  w_cs_nxt;
    logic                  w_load;

    logic [c_FRAME-1:0]    w_frame;
    logic [LEAD_BITS-1:0]  w_lead;
    logic [DATA_BITS-1:0]  w_data;

    logic [DATA_BITS-1:0]  r_sample_data;
    logic                  r_sample_valid;
    logic                  r_frame_error;
    logic                  r_overrun;
    logic [7:0]            r_overrun_count;

    // Complete frame as seen on the final capture edge
    assign w_frame = {r_shift, adc_sdo};
    assign w_lead  = w_frame[c_FRAME-1 -: LEAD_BITS];
    assign w_data  = w_frame[DATA_BITS-1:0];

    // FSM state, counters, shift register and chip-select register
    always_ff @(posedge clk48) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_quiet_cnt <= '0;
            r_shift     <= '0;
            r_cs        <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_quiet_cnt <= w_quiet_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_cs        <= w_cs_nxt;
        end
    end

    // Next-state logic: framing, bit counting and end-of-frame load strobe
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_quiet_cnt_nxt = r_quiet_cnt;
        w_shift_nxt     = r_shift;
        w_cs_nxt        = 1'b1;
        w_load          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_cs_nxt      = 1'b0;
                end
            end

            ST_SHIFT: begin
                // A frame always runs to completion once started
                w_cs_nxt      = 1'b0;
                w_shift_nxt   = {r_shift[c_FRAME-3:0], adc_sdo};
                w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                if (r_bit_cnt == c_LAST_BIT) begin
                    w_state_nxt     = ST_QUIET;
                    w_bit_cnt_nxt   = '0;
                    w_quiet_cnt_nxt = '0;
                    w_cs_nxt        = 1'b1;
                    w_load          = 1'b1;
                end
            end

            ST_QUIET: begin
                // adc_cs stays high for exactly QUIET_CYCLES cycles
                if (r_quiet_cnt == c_LAST_QUIET) begin
                    w_quiet_cnt_nxt = '0;
                    if (enable) begin
                        w_state_nxt   = ST_SHIFT;
                        w_bit_cnt_nxt = '0;
                        w_cs_nxt      = 1'b0;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end else begin
                    w_quiet_cnt_nxt = r_quiet_cnt + c_QCNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output register and valid/ready handshake with overrun detection
    always_ff @(posedge clk48) begin
        if (!reset_n) begin
            r_sample_data   <= '0;
            r_sample_valid  <= 1'b0;
            r_frame_error   <= 1'b0;
            r_overrun       <= 1'b0;
            r_overrun_count <= '0;
        end else begin
            r_frame_error <= w_load & (|w_lead);
            r_overrun     <= w_load & r_sample_valid & ~sample_ready;
            if (w_load) begin
                // Offset binary to two's complement: invert the MSB
                r_sample_data  <= {~w_data[DATA_BITS-1], w_data[DATA_BITS-2:0]};
                r_sample_valid <= 1'b1;
                if (r_sample_valid && !sample_ready && (r_overrun_count != 8'hFF)) begin
                    r_overrun_count <= r_overrun_count + 8'd1;
                end
            end else if (sample_ready) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

    assign adc_cs        = r_cs;
    assign sample_data   = r_sample_data;
    assign sample_valid  = r_sample_valid;
    assign frame_error   = r_frame_error;
    assign overrun       = r_overrun;
    assign overrun_count = r_overrun_count;

endmodule : adc_sample_reader
`default_nettype wire
